acc_adder_tree: RTL
===================

ACC_ADDER_TREE -- requirements
Module: acc_adder_tree

Interface
REQ-001 SHALL take parameter N_IN, default 64: number of unsigned operands; power of two, 2..256.
REQ-002 SHALL take parameter IN_W, default 4: operand width.
REQ-003 SHALL take parameter ACC_EXT, default 6: accumulator guard bits; OUT_W = IN_W + log2(N_IN) + ACC_EXT.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port mul_result, input, N_IN*IN_W: operands; operand j occupies bits [j*IN_W +: IN_W].
REQ-007 SHALL have port in_valid, input, 1: the operand beat is valid.
REQ-008 SHALL have port in_last, input, 1: the beat closes an accumulation group.
REQ-009 SHALL have port in_ready, output, 1: the block can accept a beat.
REQ-010 SHALL have port out_sum, output, OUT_W: accumulated group sum.
REQ-011 SHALL have port out_valid, output, 1: out_sum is valid.
REQ-012 SHALL have port out_ovf, output, 1: sticky overflow for the emitted group.
REQ-013 SHALL have port out_ready, input, 1: the downstream accepts the result.

Function
REQ-014 A beat SHALL be accepted on a rising edge with in_valid && in_ready; otherwise it is ignored.
REQ-015 Tree SHALL have L = log2(N_IN) levels, with a register after every level; all arithmetic is unsigned and zero-extended; level i is IN_W+i bits wide, so no level overflows.
REQ-016 Each pipeline stage SHALL carry a valid bit and a last bit alongside its data.
REQ-017 Pipeline stall: stall = out_valid && !out_ready; on stall, all tree stages, the accumulator and the outputs SHALL hold their state.
REQ-018 in_ready SHALL equal !stall, combinationally.
REQ-019 Accumulator SHALL update on a non-stalled edge when the final tree stage is valid: acc_next = acc + psum, with psum zero-extended to OUT_W.
REQ-020 When the final-stage beat has last=1, the block SHALL load out_sum with acc_next and set out_valid=1; acc and ovf SHALL clear to 0 on the same edge.
REQ-021 Latency: out_valid SHALL rise exactly L+1 edges after the accepting edge of the in_last beat, given no stall.
REQ-022 out_valid SHALL clear on an edge where out_ready=1, unless a new group result loads on that same edge, in which case it stays 1 with the new out_sum.
REQ-023 out_ovf SHALL be set if any addition within the group carried out of OUT_W bits; out_sum then holds the wrapped value modulo 2^OUT_W.
REQ-024 A group of a single beat SHALL be legal, with out_sum = psum.
REQ-025 The block SHALL sustain back-to-back beats with no bubbles when out_ready is held at 1.

Reset
REQ-026 While rst=1, the following SHALL be 0 on the next edge: all stage valid and last bits, acc, out_sum, out_valid, out_ovf. Stage data registers need not be reset.
REQ-027 Reset mid-group SHALL discard all in-flight and partially accumulated beats; the first post-reset result SHALL contain only post-reset beats.
REQ-028 in_ready SHALL be 1 in the cycle after reset deasserts.

Configuration
REQ-029 Macro ACC_ADDER_TREE_SHIFT_ACC_EN, when defined, SHALL select bit-serial MSB-first accumulation: acc_next = (acc << 1) + psum. Bits shifted out of OUT_W SHALL set ovf.
REQ-030 When ACC_ADDER_TREE_SHIFT_ACC_EN is undefined, accumulation SHALL be acc_next = acc + psum, and the shift logic SHALL be absent.

Verification (N_IN=64, IN_W=4, ACC_EXT=6, so OUT_W=16, L=6)
REQ-031 All operands 15, one beat with in_last=1, out_ready=1 -> out_valid 7 edges later, out_sum=960, out_ovf=0.
REQ-032 Three beats with all operands 1, 2, 3, last on the third -> out_sum=384; a following single beat of all 1 -> out_sum=64 on the next result.
REQ-033 out_ready=0 for 5 cycles while a result is pending -> in_ready=0 and out_sum held stable; no beat is lost or duplicated after release.
REQ-034 rst pulsed after 2 beats of all 5, then one beat of all 1 with last -> out_sum=64.
REQ-035 70 beats of all 15, last on beat 70 (sum 67200 > 65535) -> out_ovf=1, out_sum=1664.
REQ-036 With SHIFT_ACC_EN defined: beats all 1 then all 1 with last -> out_sum=192; without it -> out_sum=128.

Source files
------------

// File: rtl/acc_adder_tree.sv
// acc_adder_tree: pipelined unsigned adder tree feeding a group accumulator with sticky overflow.
// Define ACC_ADDER_TREE_SHIFT_ACC_EN for bit-serial MSB-first accumulation (acc << 1) + psum.
module acc_adder_tree #(
   parameter  int N_IN    = 64,
   parameter  int IN_W    = 4,
   parameter  int ACC_EXT = 6,
   localparam int L       = $clog2(N_IN),
   localparam int OUT_W   = IN_W + L + ACC_EXT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_IN*IN_W-1:0] mul_result,
   input  logic                 in_valid,
   input  logic                 in_last,
   output logic                 in_ready,
   output logic [OUT_W-1:0]     out_sum,
   output logic                 out_valid,
   output logic                 out_ovf,
   input  logic                 out_ready
);
   localparam int PW = IN_W + L;
   logic             stall;
   logic [PW-1:0]    psum;
   logic             fin_v, fin_l;
   logic [OUT_W-1:0] acc_q, acc_d, out_sum_q;
   logic             ovf_q, ovf_d, out_valid_q, out_ovf_q;
   logic [OUT_W:0]   ext;
   assign stall    = out_valid_q && !out_ready;
   assign in_ready = !stall;
   // level 0 registers the raw operands; level k holds N_IN>>k partial sums of IN_W+k bits
   genvar k, j;
   for (k = 0; k <= L; k++) begin : g_lvl
      localparam int W = IN_W + k;
      localparam int M = N_IN >> k;
      logic [M*W-1:0] d_d, d_q;
      logic           v_d, l_d, v_q, l_q;
      if (k == 0) begin : g_in
         assign d_d = mul_result;
         assign v_d = in_valid;
         assign l_d = in_last;
      end else begin : g_add
         for (j = 0; j < M; j++) begin : g_j
            assign d_d[j*W +: W] = W'(g_lvl[k-1].d_q[2*j*(W-1) +: W-1])
                                 + W'(g_lvl[k-1].d_q[(2*j+1)*(W-1) +: W-1]);
         end
         assign v_d = g_lvl[k-1].v_q;
         assign l_d = g_lvl[k-1].l_q;
      end
      always_ff @(posedge clk) begin
         if (rst) begin
            v_q <= 1'b0;
            l_q <= 1'b0;
         end else if (!stall) begin
            v_q <= v_d;
            l_q <= l_d && v_d;
         end
      end
      always_ff @(posedge clk) begin
         if (!stall) d_q <= d_d;
      end
   end
   assign psum  = g_lvl[L].d_q;
   assign fin_v = g_lvl[L].v_q;
   assign fin_l = g_lvl[L].l_q;
`ifdef ACC_ADDER_TREE_SHIFT_ACC_EN
   assign ext   = {1'b0, acc_q[OUT_W-2:0], 1'b0} + (OUT_W+1)'(psum);
   assign ovf_d = ovf_q | acc_q[OUT_W-1] | ext[OUT_W];
`else
   assign ext   = {1'b0, acc_q} + (OUT_W+1)'(psum);
   assign ovf_d = ovf_q | ext[OUT_W];
`endif
   assign acc_d = ext[OUT_W-1:0];
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         out_sum_q   <= '0;
         out_valid_q <= 1'b0;
         out_ovf_q   <= 1'b0;
      end else if (!stall) begin
         out_valid_q <= fin_v && fin_l;
         if (fin_v) begin
            acc_q <= fin_l ? '0 : acc_d;
            ovf_q <= fin_l ? 1'b0 : ovf_d;
            if (fin_l) begin
               out_sum_q <= acc_d;
               out_ovf_q <= ovf_d;
            end
         end
      end
   end
   assign out_sum   = out_sum_q;
   assign out_valid = out_valid_q;
   assign out_ovf   = out_ovf_q;
endmodule
